id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage MIPS core, directly downstream of the forwarding detect unit.
- Consumes `rs_select`/`rt_select` and picks each operand from one of four sources: register file, EX result, MEM result or WB result.
- Detects load-use hazards against its own registered EX-stage instruction and inserts one bubble with a front-end stall.
- Latches the resolved operands and control for the EX stage, honouring flush from branch resolution.

Parameters:
- `DW`, 32, datapath width.
- `CTRL_W`, 8, opaque ALU/branch control bundle width, passed through unchanged.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  32  PC of the ID instruction.
- `id_rs`, `id_rt`, `id_rd`  in  5 each  source and destination register numbers.
- `id_imm`  in  DW  sign/zero-extended immediate.
- `id_ctrl`  in  CTRL_W  decoded control bundle.
- `id_wen`  in  1  instruction writes the register file.
- `id_mem_read`  in  1  instruction is a load.
- `rf_rs_data`, `rf_rt_data`  in  DW each  register file read data.
- `rs_select`, `rt_select`  in  2 each  forwarding selects: 00 = regfile, 01 = EX, 10 = MEM, 11 = WB.
- `exe_fwd_data`, `mem_fwd_data`, `wb_fwd_data`  in  DW each  forwarding sources.
- `flush`  in  1  kill the ID instruction (taken branch or jump).
- `ex_valid`  out  1  EX-stage instruction valid.
- `ex_pc`  out  32  registered PC.
- `ex_rs_val`, `ex_rt_val`  out  DW each  resolved operands.
- `ex_imm`  out  DW  registered immediate.
- `ex_rd`  out  5  registered destination register.
- `ex_ctrl`  out  CTRL_W  registered control bundle.
- `ex_wen`, `ex_mem_read`  out  1 each  registered write-enable and load flag.
- `stall_out`  out  1  hold PC and IF/ID this cycle (combinational).

Behaviour:
- Reset (async, `rst_n` = 0):
  - all registered outputs are 0: `ex_valid` = 0, `ex_wen` = 0, `ex_mem_read` = 0, data, ctrl and `ex_rd` = 0.
  - `stall_out` evaluates to 0 because `ex_valid` = 0.
- Operand mux (combinational):
  - `op_rs` = select-indexed source per the 2-bit encoding; `op_rt` likewise.
  - If the source register number is 0, the operand is forced to 0 whatever the select.
- Load-use hazard (combinational), `lu` is true when all of:
  - `ex_valid` and `ex_mem_read` and `ex_wen` and `ex_rd` != 0;
  - `id_valid`;
  - `ex_rd` == `id_rs` or `ex_rd` == `id_rt`.
- `stall_out` = `lu` and not `flush`.
- Register update on each rising `clk`, priority `flush` > `lu` > normal:
  - `flush`: load a bubble (`ex_valid` = 0, `ex_wen` = 0, `ex_mem_read` = 0, other fields don't-care, driven 0).
  - `lu`: load a bubble. `stall_out` holds ID, so the same instruction is re-presented next cycle. The load has then moved to MEM and the detect unit supplies select 10.
  - normal: capture `id_*`, `op_rs`, `op_rt`. `ex_valid` = `id_valid`; `ex_wen` and `ex_mem_read` are gated by `id_valid`.
- Latency: one cycle from ID to the `ex_*` outputs.
- A load-use stall lasts exactly one cycle, because the bubble clears `ex_mem_read`.
- Back-to-back loads each stall independently.
- `flush` during `lu`: bubble, `stall_out` = 0, and the front end redirects.
- `id_valid` = 0: bubble, no hazard, no stall.
- Reset asserted mid-stall: all state clears immediately; no pending stall survives.
- No arithmetic; all widths pass through unchanged.

Decomposition:
- Shared package `mips_pkg`:
  - select encodings `FWD_RF` = 2'b00, `FWD_EXE` = 2'b01, `FWD_MEM` = 2'b10, `FWD_WB` = 2'b11;
  - `REG_ZERO` = 5'd0;
  - `DW` default.
- One natural sub-module `fwd_mux` (4:1 operand select with r0 forcing), instantiated twice (rs, rt).
- Hazard check and pipeline register stay in the top module.

Test Plan:
- Reset: hold `rst_n` = 0 with random inputs, then release → all `ex_*` = 0 and `stall_out` = 0 until the first valid capture.
- Forwarding:
  - `id_rs` = 3, `rs_select` = 01, `exe_fwd_data` = 0xAAAA0001 → next cycle `ex_rs_val` = 0xAAAA0001.
  - Repeat with selects 10, 11 and 00 using distinct values for each source → the matching source appears.
- r0 forcing: `id_rt` = 0, `rt_select` = 10, `mem_fwd_data` = 0xDEADBEEF → `ex_rt_val` = 0.
- Load-use:
  - Cycle 0: lw with `id_rd` = 5, `id_wen` = 1, `id_mem_read` = 1.
  - Cycle 1: add with `id_rs` = 5 → `stall_out` = 1 and `ex_valid` = 0 at cycle 2.
  - Cycle 2: same add re-presented with `rs_select` = 10 → `stall_out` = 0 and `ex_rs_val` = `mem_fwd_data` at cycle 3.
- Flush priority: set up the load-use condition as above and assert `flush` in cycle 1 → `stall_out` = 0, and at cycle 2 `ex_valid` = 0, `ex_wen` = 0, `ex_mem_read` = 0.
- Async reset mid-stall: assert `rst_n` = 0 between clock edges while `stall_out` = 1 → outputs clear without waiting for `clk`, and `stall_out` drops to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: forwarding select encodings,
// the hard-wired zero register and the default datapath width.
package mips_pkg;

    localparam int DEFAULT_DW = 32;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_mux.sv
// 4:1 operand select between register file and the three forwarding sources.
// Register r0 always reads as zero regardless of the select.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic [4:0]    reg_num,
    input  logic [1:0]    sel,
    input  logic [DW-1:0] rf_data,
    input  logic [DW-1:0] exe_data,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] op
);

    always_comb begin
        op = '0;
        if (reg_num != REG_ZERO) begin
            case (sel)
                FWD_RF:  op = rf_data;
                FWD_EXE: op = exe_data;
                FWD_MEM: op = mem_data;
                default: op = wb_data;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves forwarded operands, detects load-use
// hazards against the instruction already in EX, and handles flush.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW     = DEFAULT_DW,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DW-1:0]     id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_wen,
    input  logic              id_mem_read,
    input  logic [DW-1:0]     rf_rs_data,
    input  logic [DW-1:0]     rf_rt_data,
    input  logic [1:0]        rs_select,
    input  logic [1:0]        rt_select,
    input  logic [DW-1:0]     exe_fwd_data,
    input  logic [DW-1:0]     mem_fwd_data,
    input  logic [DW-1:0]     wb_fwd_data,
    input  logic              flush,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [DW-1:0]     ex_rs_val,
    output logic [DW-1:0]     ex_rt_val,
    output logic [DW-1:0]     ex_imm,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_wen,
    output logic              ex_mem_read,
    output logic              stall_out
);

    logic [DW-1:0] op_rs;
    logic [DW-1:0] op_rt;
    logic          lu;

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [DW-1:0]     rs_val_q, rs_val_d;
    logic [DW-1:0]     rt_val_q, rt_val_d;
    logic [DW-1:0]     imm_q, imm_d;
    logic [4:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              wen_q, wen_d;
    logic              mem_read_q, mem_read_d;

    fwd_mux #(.DW(DW)) u_rs_mux (
        .reg_num  (id_rs),
        .sel      (rs_select),
        .rf_data  (rf_rs_data),
        .exe_data (exe_fwd_data),
        .mem_data (mem_fwd_data),
        .wb_data  (wb_fwd_data),
        .op       (op_rs)
    );

    fwd_mux #(.DW(DW)) u_rt_mux (
        .reg_num  (id_rt),
        .sel      (rt_select),
        .rf_data  (rf_rt_data),
        .exe_data (exe_fwd_data),
        .mem_data (mem_fwd_data),
        .wb_data  (wb_fwd_data),
        .op       (op_rt)
    );

    // A load in EX cannot forward yet; its consumer must wait one cycle.
    assign lu = valid_q && mem_read_q && wen_q && (rd_q != REG_ZERO) &&
                id_valid && ((rd_q == id_rs) || (rd_q == id_rt));

    assign stall_out = lu && !flush;

    always_comb begin
        valid_d    = 1'b0;
        pc_d       = '0;
        rs_val_d   = '0;
        rt_val_d   = '0;
        imm_d      = '0;
        rd_d       = '0;
        ctrl_d     = '0;
        wen_d      = 1'b0;
        mem_read_d = 1'b0;
        if (!flush && !lu && id_valid) begin
            valid_d    = 1'b1;
            pc_d       = id_pc;
            rs_val_d   = op_rs;
            rt_val_d   = op_rt;
            imm_d      = id_imm;
            rd_d       = id_rd;
            ctrl_d     = id_ctrl;
            wen_d      = id_wen;
            mem_read_d = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
            wen_q      <= 1'b0;
            mem_read_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs_val_q   <= rs_val_d;
            rt_val_q   <= rt_val_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            wen_q      <= wen_d;
            mem_read_q <= mem_read_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs_val   = rs_val_q;
    assign ex_rt_val   = rt_val_q;
    assign ex_imm      = imm_q;
    assign ex_rd       = rd_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_wen      = wen_q;
    assign ex_mem_read = mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, forwarding selects, r0 forcing,
// load-use stalls, flush priority and asynchronous reset during a stall.
module tb_id_ex_stage;

    localparam int DW     = 32;
    localparam int CTRL_W = 8;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [DW-1:0]     id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_wen, id_mem_read;
    logic [DW-1:0]     rf_rs_data, rf_rt_data;
    logic [1:0]        rs_select, rt_select;
    logic [DW-1:0]     exe_fwd_data, mem_fwd_data, wb_fwd_data;
    logic              flush;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [DW-1:0]     ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_wen, ex_mem_read;
    logic              stall_out;

    int vec_cnt;
    int miscompare_cnt;

    id_ex_stage #(.DW(DW), .CTRL_W(CTRL_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .id_wen       (id_wen),
        .id_mem_read  (id_mem_read),
        .rf_rs_data   (rf_rs_data),
        .rf_rt_data   (rf_rt_data),
        .rs_select    (rs_select),
        .rt_select    (rt_select),
        .exe_fwd_data (exe_fwd_data),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_data  (wb_fwd_data),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs_val    (ex_rs_val),
        .ex_rt_val    (ex_rt_val),
        .ex_imm       (ex_imm),
        .ex_rd        (ex_rd),
        .ex_ctrl      (ex_ctrl),
        .ex_wen       (ex_wen),
        .ex_mem_read  (ex_mem_read),
        .stall_out    (stall_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid     = 1'b0;
        id_pc        = '0;
        id_rs        = '0;
        id_rt        = '0;
        id_rd        = '0;
        id_imm       = '0;
        id_ctrl      = '0;
        id_wen       = 1'b0;
        id_mem_read  = 1'b0;
        rf_rs_data   = '0;
        rf_rt_data   = '0;
        rs_select    = 2'b00;
        rt_select    = 2'b00;
        exe_fwd_data = '0;
        mem_fwd_data = '0;
        wb_fwd_data  = '0;
        flush        = 1'b0;
    endtask

    // Present an instruction in ID with plain register-file operands.
    task automatic present(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic wen, input logic mr);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_wen      = wen;
        id_mem_read = mr;
        rs_select   = 2'b00;
        rt_select   = 2'b00;
    endtask

    logic [1:0]  sel_tab [4];
    logic [31:0] exp_tab [4];

    initial begin
        vec_cnt        = 0;
        miscompare_cnt = 0;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            id_valid     = 1'($urandom);
            id_pc        = $urandom;
            id_rs        = 5'($urandom);
            id_rt        = 5'($urandom);
            id_rd        = 5'($urandom);
            id_imm       = $urandom;
            id_ctrl      = 8'($urandom);
            id_wen       = 1'($urandom);
            id_mem_read  = 1'($urandom);
            rf_rs_data   = $urandom;
            rf_rt_data   = $urandom;
            rs_select    = 2'($urandom);
            rt_select    = 2'($urandom);
            exe_fwd_data = $urandom;
            mem_fwd_data = $urandom;
            wb_fwd_data  = $urandom;
            flush        = 1'($urandom);
            tick();
        end
        chk("rst ex_valid", 64'(ex_valid), 64'd0);
        chk("rst ex_wen", 64'(ex_wen), 64'd0);
        chk("rst ex_mem_read", 64'(ex_mem_read), 64'd0);
        chk("rst ex_pc", 64'(ex_pc), 64'd0);
        chk("rst ex_rs_val", 64'(ex_rs_val), 64'd0);
        chk("rst ex_rd", 64'(ex_rd), 64'd0);
        chk("rst ex_ctrl", 64'(ex_ctrl), 64'd0);
        chk("rst stall_out", 64'(stall_out), 64'd0);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        chk("post-rst ex_valid", 64'(ex_valid), 64'd0);
        chk("post-rst ex_rt_val", 64'(ex_rt_val), 64'd0);
        chk("post-rst stall_out", 64'(stall_out), 64'd0);

        // Forwarding: each select picks its own distinct source
        rf_rs_data   = 32'h1111_0000;
        exe_fwd_data = 32'hAAAA_0001;
        mem_fwd_data = 32'hBBBB_0002;
        wb_fwd_data  = 32'hCCCC_0003;
        sel_tab[0] = 2'b01; exp_tab[0] = 32'hAAAA_0001;
        sel_tab[1] = 2'b10; exp_tab[1] = 32'hBBBB_0002;
        sel_tab[2] = 2'b11; exp_tab[2] = 32'hCCCC_0003;
        sel_tab[3] = 2'b00; exp_tab[3] = 32'h1111_0000;
        for (int i = 0; i < 4; i++) begin
            present(32'h0000_0100 + 32'(i * 4), 5'd3, 5'd4, 5'd8, 1'b1, 1'b0);
            id_imm    = 32'hFFFF_FF00 + 32'(i);
            id_ctrl   = 8'h5A + 8'(i);
            rs_select = sel_tab[i];
            tick();
            chk($sformatf("fwd sel=%0d ex_rs_val", sel_tab[i]), 64'(ex_rs_val), 64'(exp_tab[i]));
            chk($sformatf("fwd sel=%0d ex_pc", sel_tab[i]), 64'(ex_pc), 64'(32'h0000_0100 + 32'(i * 4)));
        end
        chk("fwd ex_valid", 64'(ex_valid), 64'd1);
        chk("fwd ex_imm", 64'(ex_imm), 64'h0000_0000_FFFF_FF03);
        chk("fwd ex_ctrl", 64'(ex_ctrl), 64'h5D);
        chk("fwd ex_rd", 64'(ex_rd), 64'd8);
        chk("fwd ex_wen", 64'(ex_wen), 64'd1);

        // r0 forcing on rt, then a non-zero rt through the same select
        mem_fwd_data = 32'hDEAD_BEEF;
        present(32'h200, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0);
        rt_select = 2'b10;
        tick();
        chk("r0 ex_rt_val", 64'(ex_rt_val), 64'd0);
        present(32'h204, 5'd1, 5'd7, 5'd9, 1'b0, 1'b0);
        rt_select = 2'b10;
        tick();
        chk("rt7 mem ex_rt_val", 64'(ex_rt_val), 64'hDEAD_BEEF);

        // Load-use: lw r5, then add using r5
        present(32'h300, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        tick();
        chk("lu lw ex_mem_read", 64'(ex_mem_read), 64'd1);
        present(32'h304, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
        #1;
        chk("lu stall_out", 64'(stall_out), 64'd1);
        tick();
        chk("lu bubble ex_valid", 64'(ex_valid), 64'd0);
        chk("lu bubble ex_wen", 64'(ex_wen), 64'd0);
        mem_fwd_data = 32'h1234_5678;
        rs_select    = 2'b10;
        #1;
        chk("lu replay stall_out", 64'(stall_out), 64'd0);
        tick();
        chk("lu replay ex_valid", 64'(ex_valid), 64'd1);
        chk("lu replay ex_rs_val", 64'(ex_rs_val), 64'h1234_5678);
        chk("lu replay ex_rd", 64'(ex_rd), 64'd7);
        chk("lu replay ex_pc", 64'(ex_pc), 64'h304);

        // Back-to-back loads: lw r5 ; lw r6 <- r5 ; add <- r6 (via rt)
        present(32'h400, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        tick();
        present(32'h404, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1);
        #1;
        chk("b2b first stall_out", 64'(stall_out), 64'd1);
        tick();
        rs_select = 2'b10;
        #1;
        chk("b2b replay stall_out", 64'(stall_out), 64'd0);
        tick();
        chk("b2b lw2 ex_mem_read", 64'(ex_mem_read), 64'd1);
        present(32'h408, 5'd1, 5'd6, 5'd10, 1'b1, 1'b0);
        #1;
        chk("b2b second stall_out", 64'(stall_out), 64'd1);
        tick();
        chk("b2b second bubble", 64'(ex_valid), 64'd0);
        rt_select = 2'b10;
        tick();

        // Flush wins over load-use
        present(32'h500, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        tick();
        present(32'h504, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush stall_out", 64'(stall_out), 64'd0);
        tick();
        chk("flush ex_valid", 64'(ex_valid), 64'd0);
        chk("flush ex_wen", 64'(ex_wen), 64'd0);
        chk("flush ex_mem_read", 64'(ex_mem_read), 64'd0);
        flush = 1'b0;
        idle_inputs();
        tick();
        chk("id_valid=0 ex_valid", 64'(ex_valid), 64'd0);
        chk("id_valid=0 stall_out", 64'(stall_out), 64'd0);

        // Asynchronous reset while stalled, between clock edges
        present(32'h600, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        tick();
        present(32'h604, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
        #1;
        chk("arst pre stall_out", 64'(stall_out), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst ex_valid", 64'(ex_valid), 64'd0);
        chk("arst ex_mem_read", 64'(ex_mem_read), 64'd0);
        chk("arst ex_pc", 64'(ex_pc), 64'd0);
        chk("arst stall_out", 64'(stall_out), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst release ex_valid", 64'(ex_valid), 64'd1);
        chk("arst release ex_pc", 64'(ex_pc), 64'h604);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
